jtsdram_check: RTL and testbench
================================

Name: jtsdram_check

Overview:
SDRAM read-back checker. It sits between the SDRAM controller read-data path and the LED indicator stage, and produces the sticky `bad` flag that the LED stage consumes. Expected data comes from a seeded 16-bit LFSR that advances once per read word. The block counts mismatches, captures the first failure for debug/OSD, and counts completed passes.

Parameters:
DW, 16, data width; the LFSR is DW bits, and only DW=16 is supported.
AW, 22, word-counter width; one pass = 2^AW read words.
CW, 8, error-counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that begins a pass
seed  in  DW  LFSR seed, sampled on an accepted start
rd_valid  in  1  rd_data is valid this cycle (SDRAM read ack)
rd_data  in  DW  word read from SDRAM
clr  in  1  clears bad, err_cnt and the capture registers
busy  out  1  pass in progress
done  out  1  one-cycle pulse at the end of a pass
bad  out  1  sticky mismatch flag, feeds the LED stage
err_cnt  out  CW  saturating mismatch count
err_addr  out  AW  word index of the first mismatch
err_exp  out  DW  expected value at the first mismatch
err_got  out  DW  read value at the first mismatch
passes  out  8  completed passes, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs and state are 0 during reset; FSM in IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 -> RUN next cycle.
  - Load lfsr=seed, or 16'h0001 if seed==0, since zero is the LFSR lock-up state.
  - Set word_cnt=0 and busy=1.
- RUN:
  - On each rd_valid: compare rd_data against lfsr, advance lfsr, increment word_cnt.
  - rd_valid with word_cnt==2^AW-1 -> FIN.
- FIN, one cycle: done=1, busy=0, passes+=1 -> IDLE.
- LFSR step (Galois, right shift): next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Compare is registered. On a mismatch, bad, err_cnt and capture update 1 cycle after the offending rd_valid. For the last word this is the same cycle as done.
- err_cnt saturates at 2^CW-1 and never wraps.
- Capture (err_addr/err_exp/err_got) is written only when err_cnt==0 at the time of the mismatch. err_addr = word_cnt of the failing word.
- bad stays set across passes. It is cleared only by rst_n or clr.
- clr in the same cycle as a registered mismatch:
  - the clear applies, then the mismatch is recorded;
  - result: bad=1, err_cnt=1, capture = the new error.
- Error recording is never lost.
- start while busy, or in FIN: ignored, with no seed reload.
- rd_valid in IDLE/FIN: ignored; no compare, no count.
- Reset asserted mid-pass: immediate return to IDLE, all outputs 0, no done pulse.
- clr has no effect on the FSM, lfsr, word_cnt or passes.

Decomposition:
- Package jtsdram_pkg:
  - LFSR polynomial constant 16'hB400;
  - zero-seed substitute 16'h0001;
  - FSM state typedef (IDLE/RUN/FIN).
- Sub-module jtsdram_lfsr: ports clk, rst_n, load, seed, step, q. It implements the zero-seed substitution and one step per cycle when step=1. The checker instantiates one.

Test Plan:
- Bench uses AW=4 (16 words). Correct data: seed=16'h0001, feed the LFSR sequence 0x0001, 0xB400, 0x5A00, ... for 16 words -> done pulse once, bad=0, err_cnt=0, passes=1, busy low after done.
- Single error: same run, but word 2 returns 0x5A01 -> bad rises 1 cycle later, err_cnt=1, err_addr=2, err_exp=0x5A00, err_got=0x5A01. A following clean pass keeps bad=1.
- Saturation: CW=2, all 16 words wrong -> err_cnt stops at 3, capture holds word 0.
- Zero seed and ignored inputs:
  - seed=0 -> first expected word is 0x0001;
  - a start pulse mid-pass does not reload the seed;
  - rd_valid in IDLE leaves word_cnt and err_cnt unchanged.
- clr collision: clr asserted in the same cycle a mismatch registers -> bad=1, err_cnt=1, capture = the new error. clr alone -> bad=0, err_cnt=0.
- Reset mid-pass: drop rst_n at word 7 -> busy=0, bad=0, passes=0 immediately, no done. A new start runs a full 16-word pass.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared constants and state type for the SDRAM read-back checker.
// No logic; no latency; no flow control.
// Consumers import the whole package.
package jtsdram_pkg;

  // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  // All-zero is the lock-up state, so a zero seed is replaced by this
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/jtsdram_lfsr.sv
// Seeded 16-bit Galois LFSR producing the expected read-back pattern.
// q changes one cycle after load or step; load wins over step.
// No backpressure: the owner advances it only when a word is consumed.
module jtsdram_lfsr
  import jtsdram_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          step,
  output logic [DW-1:0] q
);

  logic [DW-1:0] seed_fix;
  logic [DW-1:0] q_next;

  assign seed_fix = (seed == '0) ? DW'(LFSR_ZERO_SUB) : seed;
  assign q_next   = (q >> 1) ^ (q[0] ? DW'(LFSR_POLY) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= seed_fix;
    end else if (step) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/jtsdram_check.sv
// SDRAM read-back checker: compares each read word with an LFSR pattern, flags and logs errors.
// Mismatch is visible on bad/err_cnt/capture one cycle after the offending rd_valid.
// No backpressure: every rd_valid word in a pass is consumed the cycle it arrives.
module jtsdram_check
  import jtsdram_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 22,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] seed,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  input  logic          clr,
  output logic          busy,
  output logic          done,
  output logic          bad,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic [7:0]    passes
);

  state_t        state, state_nxt;
  logic          lfsr_load, lfsr_step;
  logic [DW-1:0] lfsr_q;
  logic [AW-1:0] word_cnt;

  // Registered compare stage
  logic          cmp_vld;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] cmp_exp, cmp_got;

  logic [CW-1:0] cnt_base;

  jtsdram_lfsr #(.DW(DW)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rd_valid) begin
          lfsr_step = 1'b1;
          if (word_cnt == '1) state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      passes   <= '0;
    end else begin
      if (lfsr_load)      word_cnt <= '0;
      else if (lfsr_step) word_cnt <= word_cnt + AW'(1);
      if (state == FIN)   passes <= passes + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      cmp_exp  <= '0;
      cmp_got  <= '0;
    end else begin
      cmp_vld <= lfsr_step && (rd_data != lfsr_q);
      if (lfsr_step) begin
        cmp_addr <= word_cnt;
        cmp_exp  <= lfsr_q;
        cmp_got  <= rd_data;
      end
    end
  end

  // A clear coinciding with a new mismatch wipes the old log first, so the new error is kept
  assign cnt_base = clr ? '0 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad      <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (cmp_vld) begin
      bad <= 1'b1;
      if (cnt_base != '1) err_cnt <= cnt_base + CW'(1);
      else                err_cnt <= cnt_base;
      if (cnt_base == '0) begin
        err_addr <= cmp_addr;
        err_exp  <= cmp_exp;
        err_got  <= cmp_got;
      end
    end else if (clr) begin
      bad      <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end
  end

endmodule

// File: tb/tb_jtsdram_check.sv
// Directed bench for jtsdram_check (AW=4, CW=2) with a transaction-level reference model
// compared against every output on every falling edge.
module tb_jtsdram_check;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        clr;
  logic        busy;
  logic        done;
  logic        bad;
  logic [1:0]  err_cnt;
  logic [3:0]  err_addr;
  logic [15:0] err_exp;
  logic [15:0] err_got;
  logic [7:0]  passes;

  int n_vec  = 0;
  int n_fail = 0;

  jtsdram_check #(.DW(16), .AW(4), .CW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .bad      (bad),
    .err_cnt  (err_cnt),
    .err_addr (err_addr),
    .err_exp  (err_exp),
    .err_got  (err_got),
    .passes   (passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word n of a pass started with seed s
  function automatic logic [15:0] lfsr_at(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = (s == 16'h0) ? 16'h0001 : s;
    for (int k = 0; k < n; k++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: pass in progress, words consumed, pending mismatch, error log
  logic        m_run, m_fin, p_vld;
  int          m_words, m_cnt;
  logic [15:0] m_seed, p_exp, p_got, m_exp, m_got;
  logic [3:0]  p_addr, m_addr;
  logic [7:0]  m_pass;
  logic        m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_fin <= 0; p_vld <= 0; m_words <= 0; m_cnt <= 0;
      m_seed <= 0; p_exp <= 0; p_got <= 0; p_addr <= 0;
      m_exp <= 0; m_got <= 0; m_addr <= 0; m_pass <= 0; m_bad <= 0;
    end else begin
      m_fin <= 1'b0;
      if (m_fin) m_pass <= m_pass + 8'd1;
      p_vld <= 1'b0;
      if (m_run) begin
        if (rd_valid) begin
          p_vld   <= (rd_data != lfsr_at(m_seed, m_words));
          p_addr  <= 4'(m_words);
          p_exp   <= lfsr_at(m_seed, m_words);
          p_got   <= rd_data;
          m_words <= m_words + 1;
          if (m_words == 15) begin
            m_run <= 1'b0;
            m_fin <= 1'b1;
          end
        end
      end else if (start && !m_fin) begin
        m_run   <= 1'b1;
        m_seed  <= seed;
        m_words <= 0;
      end
      if (p_vld) begin
        m_bad <= 1'b1;
        m_cnt <= clr ? 1 : ((m_cnt >= 3) ? 3 : m_cnt + 1);
        if (clr || m_cnt == 0) begin
          m_addr <= p_addr; m_exp <= p_exp; m_got <= p_got;
        end
      end else if (clr) begin
        m_bad <= 0; m_cnt <= 0; m_addr <= 0; m_exp <= 0; m_got <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",     busy,     m_run);
    chk("done",     done,     m_fin);
    chk("bad",      bad,      m_bad);
    chk("err_cnt",  err_cnt,  m_cnt);
    chk("err_addr", err_addr, m_addr);
    chk("err_exp",  err_exp,  m_exp);
    chk("err_got",  err_got,  m_got);
    chk("passes",   passes,   m_pass);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One full pass. Words flagged in bad_mask are XORed with xr; clr is raised on the
  // cycle after word clr_after; a stray start (seed 1234) is sent with word restart_at.
  task automatic run_pass(input logic [15:0] s, input logic [15:0] bad_mask,
                          input logic [15:0] xr, input int clr_after,
                          input int restart_at, input bit gaps);
    logic clr_next;
    clr_next = 1'b0;
    start = 1'b1; seed = s; step();
    start = 1'b0; seed = 16'h0;
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1;
      rd_data  = lfsr_at(s, i) ^ (bad_mask[i] ? xr : 16'h0);
      clr      = clr_next;
      clr_next = (i == clr_after);
      start    = (i == restart_at);
      seed     = (i == restart_at) ? 16'h1234 : 16'h0;
      step();
      if (gaps && (i % 2 == 1)) begin
        rd_valid = 1'b0; start = 1'b0; seed = 16'h0;
        clr = clr_next; clr_next = 1'b0;
        step();
      end
    end
    // Completion cycle: start and rd_valid here must both be ignored
    rd_valid = 1'b1; rd_data = 16'hDEAD; start = 1'b1; seed = 16'h5555; clr = clr_next;
    step();
    rd_valid = 1'b0; start = 1'b0; seed = 16'h0; clr = 1'b0;
    step();
    step();
  endtask

  task automatic clr_pulse();
    clr = 1'b1; step();
    clr = 1'b0; step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 16'h0; rd_valid = 1'b0; rd_data = 16'h0; clr = 1'b0;
    step(); step();
    chk("rst_busy",   busy,   0);
    chk("rst_passes", passes, 0);
    chk("rst_bad",    bad,    0);
    rst_n = 1'b1;
    step(); step();

    // Clean pass
    run_pass(16'h0001, 16'h0000, 16'h0000, -1, -1, 1'b0);
    chk("clean_passes", passes, 1);
    chk("clean_bad",    bad,    0);
    chk("clean_cnt",    err_cnt, 0);
    chk("clean_busy",   busy,   0);

    // Word 2 returns 5A01, with idle gaps between reads
    run_pass(16'h0001, 16'h0004, 16'h0001, -1, -1, 1'b1);
    chk("single_bad",  bad,      1);
    chk("single_cnt",  err_cnt,  1);
    chk("single_addr", err_addr, 2);
    chk("single_exp",  err_exp,  16'h5A00);
    chk("single_got",  err_got,  16'h5A01);

    run_pass(16'h0001, 16'h0000, 16'h0000, -1, -1, 1'b0);
    chk("sticky_bad",    bad,    1);
    chk("sticky_passes", passes, 3);

    clr_pulse();
    chk("clr_bad", bad,     0);
    chk("clr_cnt", err_cnt, 0);

    // Every word wrong: counter saturates, capture holds word 0
    run_pass(16'h0001, 16'hFFFF, 16'hFFFF, -1, -1, 1'b0);
    chk("sat_cnt",  err_cnt,  3);
    chk("sat_addr", err_addr, 0);
    chk("sat_exp",  err_exp,  16'h0001);
    chk("sat_got",  err_got,  16'hFFFE);
    clr_pulse();

    // Reads in IDLE are ignored
    rd_valid = 1'b1; rd_data = 16'h1111;
    step(); step(); step();
    rd_valid = 1'b0; step();
    chk("idle_rd_cnt", err_cnt, 0);
    chk("idle_rd_busy", busy, 0);

    // Zero seed, stray start mid-pass must not reload
    run_pass(16'h0000, 16'h0000, 16'h0000, -1, 5, 1'b0);
    chk("zseed_bad", bad,     0);
    chk("zseed_cnt", err_cnt, 0);

    run_pass(16'h0000, 16'h0001, 16'h8000, -1, -1, 1'b0);
    chk("zseed_exp",  err_exp,  16'h0001);
    chk("zseed_got",  err_got,  16'h8001);
    chk("zseed_addr", err_addr, 0);
    clr_pulse();

    // Errors at words 1 and 5; clr lands on the cycle word 5's mismatch registers
    run_pass(16'h0001, 16'h0022, 16'h0001, 5, -1, 1'b0);
    chk("coll_bad",  bad,      1);
    chk("coll_cnt",  err_cnt,  1);
    chk("coll_addr", err_addr, 5);
    chk("coll_exp",  err_exp,  16'h0B40);
    chk("coll_got",  err_got,  16'h0B41);
    clr_pulse();
    chk("clr2_bad", bad,     0);
    chk("clr2_cnt", err_cnt, 0);

    // Reset at word 7 of a pass with an error at word 3
    start = 1'b1; seed = 16'h0001; step();
    start = 1'b0; seed = 16'h0;
    for (int i = 0; i < 7; i++) begin
      rd_valid = 1'b1;
      rd_data  = lfsr_at(16'h0001, i) ^ ((i == 3) ? 16'h0100 : 16'h0);
      step();
    end
    chk("prerst_bad",  bad,  1);
    chk("prerst_busy", busy, 1);
    rd_data = lfsr_at(16'h0001, 7);
    rst_n   = 1'b0;
    #1;
    chk("rst_mid_busy",   busy,   0);
    chk("rst_mid_bad",    bad,    0);
    chk("rst_mid_passes", passes, 0);
    chk("rst_mid_done",   done,   0);
    rd_valid = 1'b0;
    step(); step();
    chk("rst_hold_done", done, 0);
    rst_n = 1'b1;
    step();
    run_pass(16'h0001, 16'h0000, 16'h0000, -1, -1, 1'b0);
    chk("post_rst_passes", passes, 1);
    chk("post_rst_bad",    bad,    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
